vend_change: RTL and testbench

Parametrised newspaper vending controller: the next generation of the team's 15-cent nickel/dime vend FSM. It adds:
- a configurable price
- quarter acceptance
- change return in nickels
- a cancel/refund button
- rejection of coins inserted while the machine is busy

It sits between the coin-acceptor front end (one-cycle coin codes) and the dispenser and change-chute actuators.

---
 rtl/vend_pkg.sv | 28 ++
 rtl/vend_change.sv | 118 +++++++++++
 tb/tb_vend_change.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the newspaper vending controller: coin codes,
// FSM state encoding and coin value decoding.
package vend_pkg;

    localparam logic [1:0] COIN_NONE    = 2'd0;
    localparam logic [1:0] COIN_NICKEL  = 2'd1;
    localparam logic [1:0] COIN_DIME    = 2'd2;
    localparam logic [1:0] COIN_QUARTER = 2'd3;

    typedef enum logic [1:0] {
        ACCEPT   = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } vend_state_t;

    // Value of a coin code in nickel units (quarter = 5 nickels).
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        logic [2:0] v;
        case (code)
            COIN_NICKEL:  v = 3'd1;
            COIN_DIME:    v = 3'd2;
            COIN_QUARTER: v = 3'd5;
            default:      v = 3'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_change.sv
// Newspaper vending controller: accumulates nickel/dime/quarter credit,
// dispenses at PRICE, pays change or refunds one nickel per cycle, and
// bounces coins inserted while a dispense or payout is in progress.
module vend_change
    import vend_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                newspaper,
    output logic                change_nickel,
    output logic                coin_return,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    // Credit must hold PRICE-1 plus a quarter without wrapping.
    if (PRICE < 1 || PRICE > (1 << CREDIT_W) - 5) begin : g_price_check
        $error("vend_change: PRICE out of range for CREDIT_W");
    end

    localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                newspaper_q, newspaper_d;
    logic                change_nickel_q, change_nickel_d;
    logic                coin_return_q, coin_return_d;
    logic                busy_q, busy_d;

    logic                coin_in;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W:0]   sum_less_price;
    logic                purchase;

    // One extra bit on the sum so the PRICE comparison never sees a wrap.
    always_comb begin
        coin_in        = (coin != COIN_NONE);
        sum            = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin));
        sum_less_price = sum - PRICE_W;
        purchase       = coin_in && (sum >= PRICE_W);
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ACCEPT;
            credit_q        <= '0;
            newspaper_q     <= 1'b0;
            change_nickel_q <= 1'b0;
            coin_return_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            newspaper_q     <= newspaper_d;
            change_nickel_q <= change_nickel_d;
            coin_return_q   <= coin_return_d;
            busy_q          <= busy_d;
        end
    end

    // Next state: purchase beats cancel; payout ends as the last nickel leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCEPT: begin
                if (coin_in) begin
                    if (purchase)
                        state_d = DISPENSE;
                    else if (cancel)
                        state_d = CHANGE;
                end else if (cancel && credit_q != '0) begin
                    state_d = CHANGE;
                end
            end
            DISPENSE: state_d = (credit_q != '0) ? CHANGE : ACCEPT;
            CHANGE:   if (credit_q <= CREDIT_W'(1)) state_d = ACCEPT;
            default:  state_d = ACCEPT;
        endcase
    end

    // Outputs and credit datapath; coins while busy go straight to the chute.
    always_comb begin
        credit_d        = credit_q;
        newspaper_d     = 1'b0;
        change_nickel_d = 1'b0;
        coin_return_d   = busy_q && coin_in;
        busy_d          = (state_d != ACCEPT);
        case (state_q)
            ACCEPT: begin
                if (coin_in) begin
                    newspaper_d = purchase;
                    credit_d    = purchase ? sum_less_price[CREDIT_W-1:0]
                                           : sum[CREDIT_W-1:0];
                end
            end
            CHANGE: begin
                if (credit_q != '0) begin
                    change_nickel_d = 1'b1;
                    credit_d        = credit_q - CREDIT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign newspaper     = newspaper_q;
    assign change_nickel = change_nickel_q;
    assign coin_return   = coin_return_q;
    assign busy          = busy_q;
    assign credit        = credit_q;

endmodule

// File: tb/tb_vend_change.sv
// Scoreboard bench for vend_change (PRICE=3, CREDIT_W=4). The driver runs a
// timeline model (credit plus "busy until edge F" and "first nickel edge")
// and queues the expected per-edge outputs; the monitor pops and compares.
module tb_vend_change;

    localparam int PRICE = 3;
    localparam int CW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    coin = 2'd0;
    logic          cancel = 1'b0;
    logic          newspaper, change_nickel, coin_return, busy;
    logic [CW-1:0] credit;

    typedef struct {
        int   edge_no;
        logic np;
        logic cn;
        logic cr;
        logic bz;
        int   cred;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_i = 0;
    int   m_credit = 0;
    int   m_free = 0;
    int   m_ns = 0;

    vend_change #(.PRICE(PRICE), .CREDIT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .coin         (coin),
        .cancel       (cancel),
        .newspaper    (newspaper),
        .change_nickel(change_nickel),
        .coin_return  (coin_return),
        .busy         (busy),
        .credit       (credit)
    );

    always #5 clock = ~clock;

    // Drive one edge worth of inputs and predict what the DUT shows after it.
    // Machine is busy for coins sampled at edges t <= m_free; nickels are
    // paid at every busy edge from m_ns through m_free.
    task automatic step(input logic [1:0] c, input logic cx, input logic r);
        exp_t e;
        int   t;
        int   v;
        int   sum;
        @(negedge clock);
        coin   = c;
        cancel = cx;
        reset  = r;
        edge_i++;
        t = edge_i;
        e = '{t, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        v = (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : (c == 2'd3) ? 5 : 0;
        if (r) begin
            m_credit = 0;
            m_free   = t;
            m_ns     = t + 1;
        end else if (t <= m_free) begin
            e.cr = (v != 0);
            if (t >= m_ns) begin
                e.cn = 1'b1;
                m_credit--;
            end
        end else begin
            sum = m_credit + v;
            if (v != 0 && sum >= PRICE) begin
                m_credit = sum - PRICE;
                e.np     = 1'b1;
                m_free   = t + 1 + m_credit;
                m_ns     = t + 2;
            end else if (v != 0) begin
                m_credit = sum;
                if (cx) begin
                    m_free = t + sum;
                    m_ns   = t + 1;
                end
            end else if (cx && m_credit > 0) begin
                m_free = t + m_credit;
                m_ns   = t + 1;
            end
        end
        e.bz   = (t < m_free);
        e.cred = m_credit;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'd0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected record per edge once the driver has started.
    always @(posedge clock) begin : monitor
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if (newspaper !== e.np || change_nickel !== e.cn || coin_return !== e.cr ||
                busy !== e.bz || int'(credit) != e.cred) begin
                n_bad++;
                $display("FAIL edge%0d outputs: got np=%0b cn=%0b cr=%0b busy=%0b credit=%0d, want np=%0b cn=%0b cr=%0b busy=%0b credit=%0d",
                         e.edge_no, newspaper, change_nickel, coin_return, busy, credit,
                         e.np, e.cn, e.cr, e.bz, e.cred);
            end
        end
    end

    initial begin
        // reset state
        step(2'd0, 1'b0, 1'b1);
        step(2'd0, 1'b0, 1'b1);
        idle(2);
        // three nickels on separate cycles
        step(2'd1, 1'b0, 1'b0); idle(1);
        step(2'd1, 1'b0, 1'b0); idle(1);
        step(2'd1, 1'b0, 1'b0); idle(3);
        // dime, dime: one nickel of change
        step(2'd2, 1'b0, 1'b0);
        step(2'd2, 1'b0, 1'b0); idle(4);
        // quarter: two nickels of change
        step(2'd3, 1'b0, 1'b0); idle(5);
        // nickel then dime with cancel: purchase wins
        step(2'd1, 1'b0, 1'b0);
        step(2'd2, 1'b1, 1'b0); idle(4);
        // nickel then cancel alone: refund one nickel
        step(2'd1, 1'b0, 1'b0);
        step(2'd0, 1'b1, 1'b0); idle(3);
        // cancel with zero credit does nothing
        step(2'd0, 1'b1, 1'b0); idle(1);
        // quarter then dime while busy: coin bounced
        step(2'd3, 1'b0, 1'b0);
        step(2'd2, 1'b0, 1'b0); idle(4);
        // quarter, reset after the first change nickel, then a fresh purchase
        step(2'd3, 1'b0, 1'b0); idle(2);
        step(2'd0, 1'b0, 1'b1); idle(2);
        step(2'd2, 1'b0, 1'b0);
        step(2'd2, 1'b0, 1'b0); idle(4);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c;
            logic       cx;
            logic       r;
            c  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            cx = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 199) == 0);
            step(c, cx, r);
        end
        idle(8);
        repeat (3) @(posedge clock);
        #2;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending records, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
